// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS load/store unit and its word-wide data memory.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } ls_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  localparam int WORD_BYTES = 4;
  localparam int MEM_WORDS  = 32;

  // Encoding 3 is treated as a full word.
  function automatic ls_size_t norm_size(input logic [1:0] raw);
    return (raw == 2'd3) ? WORD : ls_size_t'(raw);
  endfunction

  function automatic logic is_misaligned(input ls_size_t size, input logic [1:0] lo);
    return ((size == HALF) && lo[0]) || ((size == WORD) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response and memory-side signal bundle for load_store_unit.
interface load_store_unit_if #(
  parameter int ADDR_W = 32
);
  // Handshake: a request transfers on a posedge where ReqValid & ReqReady are both 1.
  // ReqReady is high only while the unit is idle, and the request fields are captured
  // at that edge, so the requester may change them afterwards. RespValid is a one-cycle
  // completion pulse that cannot be back-pressured.
  logic              ReqValid;
  logic              ReqReady;
  logic              ReqWrite;
  logic [1:0]        ReqSize;
  logic              ReqSigned;
  logic [ADDR_W-1:0] ReqAddr;
  logic [31:0]       ReqData;
  logic              RespValid;
  logic [31:0]       LoadData;
  logic              AddrErr;
  logic [31:0]       MemAddr;
  logic [31:0]       MemWriteData;
  logic [31:0]       MemReadData;
  logic              MemWriteEn;
  logic              MemReadEn;

  modport slave (
    input  ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqData, MemReadData,
    output ReqReady, RespValid, LoadData, AddrErr,
    output MemAddr, MemWriteData, MemWriteEn, MemReadEn
  );

  modport master (
    output ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqData, MemReadData,
    input  ReqReady, RespValid, LoadData, AddrErr,
    input  MemAddr, MemWriteData, MemWriteEn, MemReadEn
  );

endinterface

// File: rtl/lsu_lane_align.sv
// Little-endian lane handling: extracts/extends load data and merges sub-word stores.
module lsu_lane_align
  import mips_mem_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [31:0] old_word,
  input  logic [31:0] st_data,
  input  logic [1:0]  addr_lo,
  input  ls_size_t    size,
  input  logic        sgn,
  output logic [31:0] ld_data,
  output logic [31:0] wr_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [4:0]  byte_bit;
  logic [4:0]  half_bit;

  always_comb begin
    byte_bit = {addr_lo, 3'b000};
    half_bit = {addr_lo[1], 4'b0000};
    byte_sel = rd_word[byte_bit +: 8];
    half_sel = rd_word[half_bit +: 16];
    ld_data  = rd_word;
    wr_word  = st_data;
    case (size)
      BYTE: begin
        ld_data = {{24{sgn & byte_sel[7]}}, byte_sel};
        wr_word = old_word;
        wr_word[byte_bit +: 8] = st_data[7:0];
      end
      HALF: begin
        ld_data = {{16{sgn & half_sel[15]}}, half_sel};
        wr_word = old_word;
        wr_word[half_bit +: 16] = st_data[15:0];
      end
      default: begin
        ld_data = rd_word;
        wr_word = st_data;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer in front of a word-wide memory (combinational read, negedge write).
// Define LSU_MISALIGN_TRAP_EN to report misaligned accesses via AddrErr instead of aligning them.
module load_store_unit
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int MEM_AW = 5
) (
  input  logic                Clock,
  input  logic                Reset,
  load_store_unit_if.slave    bus,
  output lsu_state_t          dbg_state
);

  localparam int LA_W = MEM_AW + 2;

  lsu_state_t      state_q, state_d;
  logic [LA_W-1:0] addr_q, addr_d;
  ls_size_t        size_q, size_d;
  logic            signed_q, signed_d;
  logic            write_q, write_d;
  logic [31:0]     data_q, data_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [31:0]     load_data_q, load_data_d;
`ifdef LSU_MISALIGN_TRAP_EN
  logic            err_q, err_d;
`endif

  ls_size_t        req_size;
  logic [LA_W-1:0] req_addr;
  logic [31:0]     ld_ext;
  logic [31:0]     wr_merged;
  logic            unused_addr_hi;

  assign unused_addr_hi = ^bus.ReqAddr[ADDR_W-1:LA_W];

  lsu_lane_align u_align (
    .rd_word  (bus.MemReadData),
    .old_word (rdata_q),
    .st_data  (data_q),
    .addr_lo  (addr_q[1:0]),
    .size     (size_q),
    .sgn      (signed_q),
    .ld_data  (ld_ext),
    .wr_word  (wr_merged)
  );

  always_comb begin
    req_size = norm_size(bus.ReqSize);
    req_addr = bus.ReqAddr[LA_W-1:0];
`ifndef LSU_MISALIGN_TRAP_EN
    // Without the trap, misaligned addresses are rounded down to the access size.
    if (req_size == HALF) req_addr[0] = 1'b0;
    if (req_size == WORD) req_addr[1:0] = 2'b00;
`endif
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    size_d      = size_q;
    signed_d    = signed_q;
    write_d     = write_q;
    data_d      = data_q;
    rdata_d     = rdata_q;
    load_data_d = load_data_q;
`ifdef LSU_MISALIGN_TRAP_EN
    err_d       = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.ReqValid) begin
          addr_d   = req_addr;
          size_d   = req_size;
          signed_d = bus.ReqSigned;
          write_d  = bus.ReqWrite;
          data_d   = bus.ReqData;
          state_d  = (bus.ReqWrite && req_size == WORD) ? WR : RD;
`ifdef LSU_MISALIGN_TRAP_EN
          err_d = is_misaligned(req_size, bus.ReqAddr[1:0]);
          if (err_d) state_d = DONE;
`endif
        end
      end
      RD: begin
        rdata_d = bus.MemReadData;
        if (write_q) begin
          state_d = WR;
        end else begin
          load_data_d = ld_ext;
          state_d     = DONE;
        end
      end
      WR:      state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      size_q      <= BYTE;
      signed_q    <= 1'b0;
      write_q     <= 1'b0;
      data_q      <= '0;
      rdata_q     <= '0;
      load_data_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      write_q     <= write_d;
      data_q      <= data_d;
      rdata_q     <= rdata_d;
      load_data_q <= load_data_d;
`ifdef LSU_MISALIGN_TRAP_EN
      err_q       <= err_d;
`endif
    end
  end

  assign bus.ReqReady     = (state_q == IDLE);
  assign bus.RespValid    = (state_q == DONE);
  assign bus.MemReadEn    = (state_q == RD);
  assign bus.MemWriteEn   = (state_q == WR);
  assign bus.LoadData     = load_data_q;
  assign bus.MemAddr      = {{(32-MEM_AW){1'b0}}, addr_q[LA_W-1:2]};
  assign bus.MemWriteData = wr_merged;
`ifdef LSU_MISALIGN_TRAP_EN
  assign bus.AddrErr      = (state_q == DONE) && err_q;
`else
  assign bus.AddrErr      = 1'b0;
`endif
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a byte-arithmetic reference memory model.
`timescale 1ns/1ps
module tb_load_store_unit;
  import mips_mem_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_W(32)) bus ();
  lsu_state_t dbg_state;

  load_store_unit #(.ADDR_W(32), .MEM_AW(5)) dut (
    .Clock     (clk),
    .Reset     (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Memory under the unit: combinational read, negedge write.
  logic [31:0] mem [0:MEM_WORDS-1];
  assign bus.MemReadData = mem[bus.MemAddr[4:0]];
  always @(negedge clk) if (bus.MemWriteEn) mem[bus.MemAddr[4:0]] <= bus.MemWriteData;

  int overlap_cnt = 0;
  always @(negedge clk) if (bus.MemReadEn && bus.MemWriteEn) overlap_cnt++;

  // Reference model state.
  logic [31:0] ref_mem [0:MEM_WORDS-1];
  logic [31:0] ref_load;
  logic [31:0] exp_q[$];

  int n_vec = 0;
  int n_err = 0;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int size_bytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] lane_mask(input int nb);
    return (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input int off,
                                             input int nb, input bit sgn);
    logic [31:0] m, v;
    m = lane_mask(nb);
    v = (word >> (8 * off)) & m;
    if (sgn && nb < 4 && v[8 * nb - 1]) v = v | ~m;
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] old, input logic [31:0] d,
                                              input int off, input int nb);
    logic [31:0] m;
    m = lane_mask(nb) << (8 * off);
    return (old & ~m) | ((d << (8 * off)) & m);
  endfunction

  task automatic do_req(input string tag, input bit wr, input logic [1:0] sz, input bit sg,
                        input logic [31:0] addr, input logic [31:0] data);
    int nb, off, idx, g, lat, rd_n, wr_n, exp_lat, exp_rd, exp_wr;
    bit mis, got;
    logic [31:0] seen_ld, seen_err, exp_ld;
    nb  = size_bytes(sz);
    off = int'(addr[1:0]);
    idx = int'(addr[6:2]);
    mis = (off % nb) != 0;
    off = off - (off % nb);
    if (TRAP && mis) begin
      exp_lat = 1; exp_rd = 0; exp_wr = 0;
    end else if (wr) begin
      ref_mem[idx] = model_store(ref_mem[idx], data, off, nb);
      exp_lat = (nb == 4) ? 2 : 3; exp_rd = (nb == 4) ? 0 : 1; exp_wr = 1;
    end else begin
      ref_load = model_load(ref_mem[idx], off, nb, sg);
      exp_lat = 2; exp_rd = 1; exp_wr = 0;
    end
    exp_q.push_back(ref_load);

    g = 0;
    while (!bus.ReqReady && g < 10) begin @(posedge clk); #1; g++; end
    check_eq({tag, "_ready"}, 32'(bus.ReqReady), 32'd1);
    bus.ReqValid = 1'b1; bus.ReqWrite = wr; bus.ReqSize = sz;
    bus.ReqSigned = sg; bus.ReqAddr = addr; bus.ReqData = data;

    lat = 0; rd_n = 0; wr_n = 0; got = 1'b0; seen_ld = '0; seen_err = '0;
    while (!got && lat < 12) begin
      @(posedge clk); #1;
      bus.ReqValid = 1'b0;
      lat++;
      if (bus.MemReadEn) rd_n++;
      if (bus.MemWriteEn) wr_n++;
      if (bus.RespValid) begin
        got = 1'b1; seen_ld = bus.LoadData; seen_err = 32'(bus.AddrErr);
      end
    end
    exp_ld = exp_q.pop_front();
    check_eq({tag, "_resp"}, 32'(got), 32'd1);
    check_eq({tag, "_lat"}, lat, exp_lat);
    check_eq({tag, "_rd"}, rd_n, exp_rd);
    check_eq({tag, "_wr"}, wr_n, exp_wr);
    check_eq({tag, "_err"}, seen_err, 32'(TRAP && mis));
    check_eq({tag, "_load"}, seen_ld, exp_ld);
    check_eq({tag, "_mem"}, mem[idx], ref_mem[idx]);
  endtask

  initial begin
    logic [31:0] w0;
    rst = 1'b1;
    bus.ReqValid = 1'b0; bus.ReqWrite = 1'b0; bus.ReqSize = 2'd0;
    bus.ReqSigned = 1'b0; bus.ReqAddr = '0; bus.ReqData = '0;
    for (int i = 0; i < MEM_WORDS; i++) begin
      mem[i] = $urandom; ref_mem[i] = mem[i];
    end
    ref_load = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", 32'(bus.ReqReady), 32'd1);
    check_eq("rst_resp", 32'(bus.RespValid), 32'd0);
    check_eq("rst_err", 32'(bus.AddrErr), 32'd0);
    check_eq("rst_wen", 32'(bus.MemWriteEn), 32'd0);
    check_eq("rst_ren", 32'(bus.MemReadEn), 32'd0);
    check_eq("rst_load", bus.LoadData, 32'd0);
    check_eq("rst_maddr", bus.MemAddr, 32'd0);
    check_eq("rst_wdata", bus.MemWriteData, 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    @(posedge clk); #1;

    mem[1] = 32'h8899_AABB; ref_mem[1] = mem[1];
    do_req("t1_lb", 1'b0, 2'd0, 1'b1, 32'd5, 32'd0);
    check_eq("t1_const", bus.LoadData, 32'hFFFF_FFAA);
    do_req("t2_lhu", 1'b0, 2'd1, 1'b0, 32'd6, 32'd0);
    check_eq("t2_const", bus.LoadData, 32'h0000_8899);
    do_req("t3_sb", 1'b1, 2'd0, 1'b0, 32'd4, 32'h11);
    check_eq("t3_const", mem[1], 32'h8899_AA11);
    do_req("t4_sw", 1'b1, 2'd2, 1'b0, 32'd8, 32'hDEAD_BEEF);
    do_req("t4_lw", 1'b0, 2'd2, 1'b1, 32'd8, 32'd0);
    check_eq("t4_const", bus.LoadData, 32'hDEAD_BEEF);
    mem[0] = 32'hC234_5678; ref_mem[0] = mem[0];
    do_req("t5_lh3", 1'b0, 2'd1, 1'b1, 32'd3, 32'd0);
    check_eq("t5_const", bus.LoadData, TRAP ? 32'hDEAD_BEEF : 32'hFFFF_C234);

    // Reset while the read half of an SH is in flight.
    @(posedge clk); #1;
    w0 = mem[0];
    bus.ReqValid = 1'b1; bus.ReqWrite = 1'b1; bus.ReqSize = 2'd1;
    bus.ReqSigned = 1'b0; bus.ReqAddr = 32'd2; bus.ReqData = 32'h5555;
    @(posedge clk); #1;
    bus.ReqValid = 1'b0;
    check_eq("t6_in_rd", 32'(dbg_state), 32'(RD));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ref_load = '0;
    check_eq("t6_state", 32'(dbg_state), 32'(IDLE));
    check_eq("t6_ready", 32'(bus.ReqReady), 32'd1);
    check_eq("t6_wen", 32'(bus.MemWriteEn), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check_eq("t6_noresp", 32'(bus.RespValid), 32'd0);
      @(posedge clk); #1;
    end
    check_eq("t6_mem", mem[0], w0);
    check_eq("t6_load", bus.LoadData, 32'd0);

    for (int i = 0; i < 200; i++) begin
      do_req("rnd", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), $urandom, $urandom);
    end

    check_eq("rw_overlap", overlap_cnt, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
